add_pipe: RTL and testbench
===========================

ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of SEG_W.
REQ-002 Parameter SEG_W, default 8, bits added per pipeline stage; STAGES = WIDTH/SEG_W (default 4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand set present on num1/num2/carryin/sub.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 num1  input  WIDTH  first operand.
REQ-008 num2  input  WIDTH  second operand.
REQ-009 carryin  input  1  carry into bit 0 (add mode only).
REQ-010 sub  input  1  mode: 0 = num1+num2+carryin, 1 = num1-num2.
REQ-011 out_valid  output  1  result on S/carryout/ovf valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 S  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 carryout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-017 Sub mode SHALL compute num1 + ~num2 + 1, ignoring carryin.
REQ-018 Stage k (0..STAGES-1) SHALL add segment k of both operands plus the registered carry from stage k-1 (stage 0: carryin, or 1 in sub mode).
REQ-019 Upper operand segments not yet consumed SHALL be carried forward in skew registers; completed lower result segments SHALL be carried forward in deskew registers.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-021 Pipeline enable en = out_ready || !out_valid; all stages advance together when en = 1, hold when en = 0.
REQ-022 in_ready SHALL equal en (combinational; no combinational path from in_valid to in_ready).
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid = 0 on an advancing cycle) SHALL propagate as invalid slots.
REQ-024 Held results SHALL remain bit-stable on S/carryout/ovf while out_valid && !out_ready.
REQ-025 ovf SHALL be (a[MSB] == b'[MSB]) && (S[MSB] != a[MSB]), b' being num2 or ~num2 per mode.
REQ-026 Results SHALL emerge in input order; none dropped or duplicated under any valid/ready pattern.
REQ-027 Simultaneous output drain and input accept in one cycle SHALL be supported at full pipeline.

Reset
REQ-028 While rst = 1 at a clock edge, all stage valid bits SHALL clear; out_valid = 0 on the following cycle.
REQ-029 After reset S = 0, carryout = 0, ovf = 0; in_ready = 1 from the first cycle after rst deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight operands; no stale result SHALL later appear.

Structure
REQ-031 Package add_pkg SHALL hold mode constants (MODE_ADD = 0, MODE_SUB = 1) and the default WIDTH/SEG_W values.
REQ-032 One sub-module add_seg (combinational SEG_W-bit adder: a, b, cin -> s, cout, MSB carry-in for ovf) SHALL be instantiated STAGES times.
REQ-033 Parameter legality (WIDTH % SEG_W == 0, SEG_W >= 1) SHALL be checked at elaboration.

Verification
REQ-034 Add, WIDTH=32: 580+540, carryin=0 -> S=1120, carryout=0, ovf=0, after 4 cycles.
REQ-035 Add: 1024 + (-512) -> S=512, carryout=1, ovf=0; 8848 + (-8848) -> S=0, carryout=1, ovf=0.
REQ-036 Add: 0x7FFFFFFF + 1 -> S=0x80000000, ovf=1; carryin=1 with 0xFFFFFFFF+0 -> S=0, carryout=1.
REQ-037 Sub: 100 - 200 -> S=0xFFFFFF9C, carryout=0; 262 - 262 -> S=0, carryout=1.
REQ-038 Back-to-back 8 operands with out_ready toggled 1/0 per cycle -> all 8 results in order, S stable while stalled, in_ready low when full and stalled.
REQ-039 rst asserted for one cycle with 3 results in flight -> out_valid=0 next cycle, no in-flight result ever emitted; WIDTH=16, SEG_W=4 rerun of REQ-034 passes with latency 4.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared constants for the segmented pipelined adder.
package add_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEG_W_DEF = 8;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle between a producer/consumer and add_pipe.
interface add_pipe_if import add_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             carryin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             carryout;
  logic             ovf;

  modport master (
    output in_valid, num1, num2, carryin, sub, out_ready,
    input  in_ready, out_valid, S, carryout, ovf
  );

  modport slave (
    input  in_valid, num1, num2, carryin, sub, out_ready,
    output in_ready, out_valid, S, carryout, ovf
  );

endinterface

// File: rtl/add_pipe_seg.sv
// Combinational SEG_W-bit adder slice; cmsb_o is the carry into the slice MSB,
// so cmsb_o ^ cout_o gives signed overflow when this is the top slice.
module add_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SEG_W:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
  assign s_o    = sum[SEG_W-1:0];
  assign cout_o = sum[SEG_W];
  assign cmsb_o = a_i[SEG_W-1] ^ b_i[SEG_W-1] ^ s_o[SEG_W-1];

endmodule

// File: rtl/add_pipe.sv
// Carry-save-free segmented adder: one SEG_W slice per stage, operands skewed in,
// result segments deskewed out; all stages advance together under one enable.
module add_pipe import add_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input logic       clk,
  input logic       rst,
  add_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / SEG_W;

  if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_bad_param
    $error("add_pipe: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             en;
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             ovf_q;

  logic             v_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] r_in  [STAGES];
  logic [WIDTH-1:0] r_d   [STAGES];
  logic             c_d   [STAGES];
  logic             m_w   [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] s_w;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] mask;

    if (k == 0) begin : g_head
      // Subtraction is num1 + ~num2 + 1; carryin only matters when adding.
      assign v_in[k] = bus.in_valid;
      assign a_in[k] = bus.num1;
      assign b_in[k] = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.num2 : bus.num2;
      assign c_in[k] = (mode_e'(bus.sub) == MODE_SUB) ? 1'b1 : bus.carryin;
      assign r_in[k] = '0;
    end else begin : g_body
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign r_in[k] = r_q[k-1];
    end

    add_seg #(.SEG_W(SEG_W)) u_seg (
      .a_i   (a_in[k][k*SEG_W +: SEG_W]),
      .b_i   (b_in[k][k*SEG_W +: SEG_W]),
      .cin_i (c_in[k]),
      .s_o   (s_w),
      .cout_o(c_d[k]),
      .cmsb_o(m_w[k])
    );

    assign s_ext  = WIDTH'(s_w);
    assign mask   = WIDTH'({SEG_W{1'b1}}) << (k * SEG_W);
    assign r_d[k] = (r_in[k] & ~mask) | (s_ext << (k * SEG_W));
  end

  assign en = bus.out_ready || !v_q[STAGES-1];

  // Data registers only load on valid slots, so bubbles never disturb held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          r_q[k] <= r_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q <= m_w[STAGES-1] ^ c_d[STAGES-1];
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.S         = r_q[STAGES-1];
  assign bus.carryout  = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: 32/8 and 16/4 instances with hand-computed results.
module tb_add_pipe;
  import add_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32;
  logic rst16;

  add_pipe_if #(.WIDTH(32)) b32 ();
  add_pipe_if #(.WIDTH(16)) b16 ();

  add_pipe #(.WIDTH(32), .SEG_W(8)) u32 (.clk(clk), .rst(rst32), .bus(b32));
  add_pipe #(.WIDTH(16), .SEG_W(4)) u16 (.clk(clk), .rst(rst16), .bus(b16));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic s, input logic [31:0] es,
                       input logic ec, input logic eo);
    int lat;
    b32.num1 = a; b32.num2 = b; b32.carryin = cin; b32.sub = s;
    b32.in_valid = 1'b1; b32.out_ready = 1'b1;
    tick;
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 12) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " S"}, 64'(b32.S), 64'(es));
    chk({tag, " carryout"}, 64'(b32.carryout), 64'(ec));
    chk({tag, " ovf"}, 64'(b32.ovf), 64'(eo));
    tick;
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic s, input logic [15:0] es,
                       input logic ec, input logic eo);
    int lat;
    b16.num1 = a; b16.num2 = b; b16.carryin = cin; b16.sub = s;
    b16.in_valid = 1'b1; b16.out_ready = 1'b1;
    tick;
    b16.in_valid = 1'b0;
    lat = 1;
    while (!b16.out_valid && lat < 12) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " S"}, 64'(b16.S), 64'(es));
    chk({tag, " carryout"}, 64'(b16.carryout), 64'(ec));
    chk({tag, " ovf"}, 64'(b16.ovf), 64'(eo));
    tick;
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    logic        holding;
    logic [31:0] held;
    logic [32:0] exp_sum;
    logic        seen;

    sa = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF,
           32'h00FF_00FF, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0100};
    sb = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001,
           32'h0001_FF01, 32'h8000_0000, 32'h2152_4111, 32'hFFFF_FF00};

    rst32 = 1'b1; rst16 = 1'b1;
    b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.num1 = '0; b32.num2 = '0;
    b32.carryin = 1'b0; b32.sub = MODE_ADD;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.num1 = '0; b16.num2 = '0;
    b16.carryin = 1'b0; b16.sub = MODE_ADD;
    repeat (2) tick;
    rst32 = 1'b0; rst16 = 1'b0;
    #1;
    chk("reset out_valid", 64'(b32.out_valid), 64'd0);
    chk("reset S", 64'(b32.S), 64'd0);
    chk("reset carryout", 64'(b32.carryout), 64'd0);
    chk("reset ovf", 64'(b32.ovf), 64'd0);
    chk("reset in_ready", 64'(b32.in_ready), 64'd1);
    chk("reset16 out_valid", 64'(b16.out_valid), 64'd0);
    tick;

    run32("580+540",    32'd580,       32'd540,       1'b0, MODE_ADD, 32'd1120,      1'b0, 1'b0);
    run32("1024-512",   32'd1024,      32'hFFFF_FE00, 1'b0, MODE_ADD, 32'd512,       1'b1, 1'b0);
    run32("8848-8848",  32'd8848,      32'hFFFF_DD70, 1'b0, MODE_ADD, 32'd0,         1'b1, 1'b0);
    run32("maxpos+1",   32'h7FFF_FFFF, 32'd1,         1'b0, MODE_ADD, 32'h8000_0000, 1'b0, 1'b1);
    run32("cin wrap",   32'hFFFF_FFFF, 32'd0,         1'b1, MODE_ADD, 32'd0,         1'b1, 1'b0);
    run32("seg chain",  32'h00FF_FFFF, 32'd1,         1'b0, MODE_ADD, 32'h0100_0000, 1'b0, 1'b0);
    run32("sub 100-200",32'd100,       32'd200,       1'b0, MODE_SUB, 32'hFFFF_FF9C, 1'b0, 1'b0);
    run32("sub 262-262",32'd262,       32'd262,       1'b0, MODE_SUB, 32'd0,         1'b1, 1'b0);
    run32("sub cin ign",32'd5,         32'd3,         1'b1, MODE_SUB, 32'd2,         1'b1, 1'b0);
    run32("sub minneg", 32'h8000_0000, 32'd1,         1'b0, MODE_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Back-to-back stream with out_ready alternating 1/0.
    sent = 0; recv = 0; cyc = 0; holding = 1'b0; held = '0;
    b32.sub = MODE_ADD; b32.carryin = 1'b0;
    while (recv < 8 && cyc < 200) begin
      b32.out_ready = (cyc % 2 == 0);
      b32.in_valid  = (sent < 8);
      if (sent < 8) begin
        b32.num1 = sa[sent];
        b32.num2 = sb[sent];
      end
      #1;
      if (holding) begin
        chk("stream held valid", 64'(b32.out_valid), 64'd1);
        chk("stream held S", 64'(b32.S), 64'(held));
      end
      if (b32.out_valid && !b32.out_ready) begin
        chk("stream stall in_ready", 64'(b32.in_ready), 64'd0);
        holding = 1'b1;
        held    = b32.S;
      end else begin
        holding = 1'b0;
      end
      if (b32.out_valid && b32.out_ready) begin
        exp_sum = {1'b0, sa[recv]} + {1'b0, sb[recv]};
        chk("stream S", 64'(b32.S), 64'(exp_sum[31:0]));
        chk("stream carryout", 64'(b32.carryout), 64'(exp_sum[32]));
        recv++;
      end
      if (b32.in_valid && b32.in_ready) sent++;
      tick;
      cyc++;
    end
    chk("stream count", 64'(recv), 64'd8);
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    tick;

    // Three operands in flight, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      b32.num1 = 32'(i + 1); b32.num2 = 32'd10; b32.in_valid = 1'b1;
      tick;
    end
    b32.in_valid = 1'b0;
    rst32 = 1'b1;
    tick;
    rst32 = 1'b0;
    chk("midrst out_valid", 64'(b32.out_valid), 64'd0);
    chk("midrst S", 64'(b32.S), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      if (b32.out_valid) seen = 1'b1;
      tick;
    end
    chk("midrst no stale", 64'(seen), 64'd0);
    run32("post rst",   32'd7,         32'd8,         1'b0, MODE_ADD, 32'd15,        1'b0, 1'b0);

    run16("w16 580+540",32'd580,       32'd540,       1'b0, MODE_ADD, 16'd1120,      1'b0, 1'b0);
    run16("w16 maxpos", 16'h7FFF,      16'd1,         1'b0, MODE_ADD, 16'h8000,      1'b0, 1'b1);
    run16("w16 sub",    16'd100,       16'd200,       1'b0, MODE_SUB, 16'hFF9C,      1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
